// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow finish at accept and skip the iteration phase.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wr_en_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: start_i is a single-cycle request, taken only in IDLE with kill_i low;
  // hold_flag_o stalls the pipeline from that request cycle until the result cycle;
  // rd_wr_en_o is a one-cycle write-back strobe with no back-pressure.

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]        r_func3;
  logic [4:0]        r_rd_addr;
  logic [4:0]        r_rd_addr_out;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_neg1;
  logic              r_neg2;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN:0]     r_rem;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_op1_signed;
  logic              w_op2_signed;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_prod_neg;
  logic [XLEN+1:0]   w_div_shift;
  logic [XLEN+1:0]   w_div_diff;
  logic              w_div_ge;
  logic [XLEN:0]     w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_fix;
  logic              w_last;

  // ---------------- operand preparation ----------------
  always_comb begin
    w_op1_signed = 1'b0;
    w_op2_signed = 1'b0;
    case (func3_i)
      F_MUL, F_MULH, F_DIV, F_REM: begin
        w_op1_signed = 1'b1;
        w_op2_signed = 1'b1;
      end
      F_MULHSU: w_op1_signed = 1'b1;
      default: begin
        w_op1_signed = 1'b0;
        w_op2_signed = 1'b0;
      end
    endcase
  end

  assign w_accept   = start_i && !kill_i;
  assign w_neg1     = w_op1_signed && op1_i[XLEN-1];
  assign w_neg2     = w_op2_signed && op2_i[XLEN-1];
  assign w_abs1     = w_neg1 ? (~op1_i + 1'b1) : op1_i;
  assign w_abs2     = w_neg2 ? (~op2_i + 1'b1) : op2_i;
  assign w_div_zero = func3_i[2] && (op2_i == '0);
  assign w_ovf      = ((func3_i == F_DIV) || (func3_i == F_REM)) &&
                      (op1_i == MIN_INT) && (op2_i == '1);
  assign w_special  = w_div_zero || w_ovf;

  // func3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = func3_i[1] ? op1_i : '1;
    end else if (w_ovf) begin
      w_special_res = func3_i[1] ? '0 : MIN_INT;
    end
  end

  // ---------------- one iteration step ----------------
  // Multiply keeps the multiplier in the low half of r_acc and shifts it out LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_prod_neg = ~w_mul_nxt + 1'b1;

  // Divide shifts the dividend out of r_acc's low half, shifting quotient bits in.
  assign w_div_shift = {r_rem, r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {2'b00, r_b};
  assign w_div_ge    = !w_div_diff[XLEN+1];
  assign w_rem_nxt   = w_div_ge ? w_div_diff[XLEN:0] : w_div_shift[XLEN:0];
  assign w_quo_nxt   = {r_acc[XLEN-2:0], w_div_ge};

  assign w_last = (r_cnt == CNT_W'(1));

  // Sign fixup taken from the values the final iteration is about to produce
  always_comb begin
    w_fix = '0;
    case (r_func3)
      F_MUL:    w_fix = (r_neg1 ^ r_neg2) ? w_prod_neg[XLEN-1:0] : w_mul_nxt[XLEN-1:0];
      F_MULH:   w_fix = (r_neg1 ^ r_neg2) ? w_prod_neg[2*XLEN-1:XLEN]
                                          : w_mul_nxt[2*XLEN-1:XLEN];
      F_MULHSU: w_fix = r_neg1 ? w_prod_neg[2*XLEN-1:XLEN] : w_mul_nxt[2*XLEN-1:XLEN];
      F_MULHU:  w_fix = w_mul_nxt[2*XLEN-1:XLEN];
      F_DIV:    w_fix = (r_neg1 ^ r_neg2) ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
      F_DIVU:   w_fix = w_quo_nxt;
      F_REM:    w_fix = r_neg1 ? (~w_rem_nxt[XLEN-1:0] + 1'b1) : w_rem_nxt[XLEN-1:0];
      F_REMU:   w_fix = w_rem_nxt[XLEN-1:0];
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3       <= '0;
      r_rd_addr     <= '0;
      r_rd_addr_out <= '0;
      r_rd_data     <= '0;
      r_neg1        <= 1'b0;
      r_neg2        <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func3   <= func3_i;
            r_rd_addr <= rd_addr_i;
            r_neg1    <= w_neg1;
            r_neg2    <= w_neg2;
            r_a       <= w_abs1;
            r_b       <= w_abs2;
            r_acc     <= func3_i[2] ? {{XLEN{1'b0}}, w_abs1} : {{XLEN{1'b0}}, w_abs2};
            r_rem     <= '0;
            if (w_special) begin
              r_rd_data     <= w_special_res;
              r_rd_addr_out <= rd_addr_i;
              r_cnt         <= '0;
            end else begin
              r_cnt <= CNT_W'(XLEN);
            end
          end
        end
        S_CALC: begin
          if (kill_i) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_func3[2]) begin
              r_acc <= {r_acc[2*XLEN-1:XLEN], w_quo_nxt};
              r_rem <= w_rem_nxt;
            end else begin
              r_acc <= w_mul_nxt;
            end
            if (w_last) begin
              r_rd_data     <= w_fix;
              r_rd_addr_out <= r_rd_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign busy_o      = (r_state != S_IDLE);
  assign hold_flag_o = rst_n && (((r_state == S_IDLE) && w_accept) || (r_state == S_CALC));
  assign rd_wr_en_o  = (r_state == S_DONE) && !kill_i && (r_rd_addr_out != 5'd0);
  assign rd_addr_o   = r_rd_addr_out;
  assign rd_data_o   = r_rd_data;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a 32-bit and a 16-bit instance driven with directed and random
// operations; a monitor checks every write-back against an arithmetic reference model.
module tb_ex_muldiv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32_n;
  logic rst16_n;

  logic        s32_start, s32_kill;
  logic [2:0]  s32_func;
  logic [31:0] s32_op1, s32_op2;
  logic [4:0]  s32_rd;
  logic        o32_busy, o32_hold, o32_wr;
  logic [4:0]  o32_rd_addr;
  logic [31:0] o32_rd_data;
  logic [1:0]  o32_dbg;

  logic        s16_start, s16_kill;
  logic [2:0]  s16_func;
  logic [15:0] s16_op1, s16_op2;
  logic [4:0]  s16_rd;
  logic        o16_busy, o16_hold, o16_wr;
  logic [4:0]  o16_rd_addr;
  logic [15:0] o16_rd_data;
  logic [1:0]  o16_dbg;

  ex_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .start_i(s32_start), .func3_i(s32_func),
    .op1_i(s32_op1), .op2_i(s32_op2), .rd_addr_i(s32_rd), .kill_i(s32_kill),
    .busy_o(o32_busy), .hold_flag_o(o32_hold), .rd_addr_o(o32_rd_addr),
    .rd_data_o(o32_rd_data), .rd_wr_en_o(o32_wr), .dbg_state_o(o32_dbg)
  );

  ex_muldiv #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .start_i(s16_start), .func3_i(s16_func),
    .op1_i(s16_op1), .op2_i(s16_op2), .rd_addr_i(s16_rd), .kill_i(s16_kill),
    .busy_o(o16_busy), .hold_flag_o(o16_hold), .rd_addr_o(o16_rd_addr),
    .rd_data_o(o16_rd_data), .rd_wr_en_o(o16_wr), .dbg_state_o(o16_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [36:0] exp32_q[$];
  logic [20:0] exp16_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic longint sext(input logic [63:0] v, input int w);
    if (((v >> (w - 1)) & 64'd1) != 64'd0) return longint'(v) - longint'(64'd1 << w);
    return longint'(v);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [63:0] a,
                                    input logic [63:0] b, input int w);
    longint sa, sb;
    sa = sext(a, w);
    sb = sext(b, w);
    if (f[2] && b == 64'd0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && sa == -longint'(64'd1 << (w - 1)) && sb == -64'sd1)
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] mask, p, r;
    longint sa, sb, min_v;
    mask  = (64'd1 << w) - 64'd1;
    sa    = sext(a, w);
    sb    = sext(b, w);
    min_v = -longint'(64'd1 << (w - 1));
    r     = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p; end
      3'd1: begin p = sa * sb; r = p >> w; end
      3'd2: begin p = sa * longint'(b); r = p >> w; end
      3'd3: begin p = a * b; r = p >> w; end
      3'd4: begin
        if (b == 64'd0) r = mask;
        else if (sa == min_v && sb == -64'sd1) r = a;
        else r = sa / sb;
      end
      3'd5: r = (b == 64'd0) ? mask : a / b;
      3'd6: begin
        if (b == 64'd0) r = a;
        else if (sa == min_v && sb == -64'sd1) r = 64'd0;
        else r = sa % sb;
      end
      default: r = (b == 64'd0) ? a : a % b;
    endcase
    return r & mask;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic hold_of(input bit w16);
    return w16 ? o16_hold : o32_hold;
  endfunction

  function automatic logic wr_of(input bit w16);
    return w16 ? o16_wr : o32_wr;
  endfunction

  task automatic drive(input bit w16, input logic st, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    if (w16) begin
      s16_start = st; s16_func = f; s16_op1 = a[15:0]; s16_op2 = b[15:0]; s16_rd = rd;
    end else begin
      s32_start = st; s32_func = f; s32_op1 = a[31:0]; s32_op2 = b[31:0]; s32_rd = rd;
    end
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return mask;
      2: return 64'd1 << (w - 1);
      3: return 64'(int'($urandom_range(0, 20)));
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // Issue one operation (called at posedge+1 with the unit idle); checks latency and hold.
  task automatic run_op(input bit w16, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int pulse_at,
                        input string tag);
    int w, n, hold_n, exp_lat;
    bit seen;
    logic [63:0] e;
    w       = w16 ? 16 : 32;
    e       = model(f, a, b, w);
    exp_lat = is_special(f, a, b, w) ? 1 : w + 1;
    drive(w16, 1'b1, f, a, b, rd);
    if (w16) exp16_q.push_back({rd, e[15:0]});
    else     exp32_q.push_back({rd, e[31:0]});
    @(negedge clk);
    hold_n = hold_of(w16) ? 1 : 0;
    @(posedge clk); #1;
    drive(w16, 1'b0, f, a, b, rd);
    n = 1;
    seen = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      if (wr_of(w16)) begin
        seen = 1'b1;
        break;
      end
      if (hold_of(w16)) hold_n++;
      @(posedge clk); #1;
      n++;
      if (n == pulse_at) drive(w16, 1'b1, 3'($urandom_range(0, 7)), pick(w), pick(w), rd);
      else if (n == pulse_at + 1) drive(w16, 1'b0, f, a, b, rd);
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_hold_cycles"}, 64'(hold_n), 64'(exp_lat));
    if (seen) check({tag, "_hold_in_done"}, 64'(hold_of(w16)), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [36:0] e32;
    logic [20:0] e16;
    if (o32_wr) begin
      if (exp32_q.size() == 0) check("wb32_unexpected", 64'(o32_wr), 64'd0);
      else begin
        e32 = exp32_q.pop_front();
        check("wb32_addr", 64'(o32_rd_addr), 64'(e32[36:32]));
        check("wb32_data", 64'(o32_rd_data), 64'(e32[31:0]));
      end
    end
    if (o16_wr) begin
      if (exp16_q.size() == 0) check("wb16_unexpected", 64'(o16_wr), 64'd0);
      else begin
        e16 = exp16_q.pop_front();
        check("wb16_addr", 64'(o16_rd_addr), 64'(e16[20:16]));
        check("wb16_data", 64'(o16_rd_data), 64'(e16[15:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed vectors (32-bit) ----------------
  logic [2:0]  v_f[13];
  logic [31:0] v_a[13];
  logic [31:0] v_b[13];
  logic [31:0] v_e[13];

  // ---------------- main sequence ----------------
  initial begin
    int wr_cnt;
    v_f = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
    v_a = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
            32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'hFFFFFFFB};
    v_b = '{32'hFFFFFFFD, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'd0, 32'd0, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
    v_e = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'd0,
            32'hFFFFFFFF, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'hFFFFFFFF,
            32'hFFFFFFFB};

    rst32_n = 1'b0; rst16_n = 1'b0;
    s32_kill = 1'b0; s16_kill = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 64'd5, 64'd6, 5'd1);
    drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    #2;
    check("rst_busy", 64'(o32_busy), 64'd0);
    check("rst_hold_with_start", 64'(o32_hold), 64'd0);
    check("rst_addr", 64'(o32_rd_addr), 64'd0);
    check("rst_data", 64'(o32_rd_data), 64'd0);
    check("rst_wr", 64'(o32_wr), 64'd0);
    check("rst16_busy", 64'(o16_busy), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst32_n = 1'b1; rst16_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic, including the 1-cycle special cases
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, v_f[i], 64'(v_a[i]), 64'(v_b[i]), 5'(i + 1), 0, $sformatf("dir%0d", i));
      check($sformatf("dir%0d_value", i), 64'(o32_rd_data), 64'(v_e[i]));
    end

    // Kill mid-CALC: no write, unit idle next cycle, new request taken right away
    drive(1'b0, 1'b1, 3'd0, 64'd1234, 64'd5678, 5'd9);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd9);
    repeat (9) @(posedge clk);
    #1;
    s32_kill = 1'b1;
    @(posedge clk); #1;
    s32_kill = 1'b0;
    check("kill_calc_busy", 64'(o32_busy), 64'd0);
    run_op(1'b0, 3'd0, 64'd11, 64'd13, 5'd10, 0, "after_kill");

    // Kill together with start in IDLE: not accepted
    drive(1'b0, 1'b1, 3'd4, 64'd9, 64'd3, 5'd11);
    s32_kill = 1'b1;
    @(negedge clk);
    check("kill_start_hold", 64'(o32_hold), 64'd0);
    @(posedge clk); #1;
    s32_kill = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    check("kill_start_busy", 64'(o32_busy), 64'd0);

    // Kill in DONE beats the write-back
    drive(1'b0, 1'b1, 3'd5, 64'd77, 64'd0, 5'd12);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    s32_kill = 1'b1;
    @(negedge clk);
    check("kill_done_wr", 64'(o32_wr), 64'd0);
    @(posedge clk); #1;
    s32_kill = 1'b0;
    check("kill_done_busy", 64'(o32_busy), 64'd0);

    // Start pulsed mid-CALC is ignored
    run_op(1'b0, 3'd1, 64'hDEADBEEF, 64'h12345678, 5'd7, 10, "pulse");

    // rd_addr 0: operation runs but never writes
    drive(1'b0, 1'b1, 3'd0, 64'd3, 64'd4, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    wr_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (o32_wr) wr_cnt++;
    end
    check("rd0_wr_count", 64'(wr_cnt), 64'd0);
    check("rd0_idle", 64'(o32_busy), 64'd0);
    @(posedge clk); #1;

    // Random 32-bit traffic
    for (int i = 0; i < 40; i++)
      run_op(1'b0, 3'($urandom_range(0, 7)), pick(32), pick(32), 5'($urandom_range(1, 31)),
             0, $sformatf("rnd32_%0d", i));

    // 16-bit instance
    for (int i = 0; i < 20; i++)
      run_op(1'b1, 3'($urandom_range(0, 7)), pick(16), pick(16), 5'($urandom_range(1, 31)),
             0, $sformatf("rnd16_%0d", i));
    run_op(1'b1, 3'd0, 64'h00FF, 64'h0101, 5'd2, 0, "mul16");
    check("mul16_value", 64'(o16_rd_data), 64'hFFFF);

    // Reset mid-CALC on the 16-bit unit
    drive(1'b1, 1'b1, 3'd5, 64'h1234, 64'h0007, 5'd3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    repeat (5) @(posedge clk);
    #1;
    rst16_n = 1'b0;
    #1;
    check("rst16_mid_busy", 64'(o16_busy), 64'd0);
    check("rst16_mid_hold", 64'(o16_hold), 64'd0);
    check("rst16_mid_addr", 64'(o16_rd_addr), 64'd0);
    check("rst16_mid_data", 64'(o16_rd_data), 64'd0);
    check("rst16_mid_wr", 64'(o16_wr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst16_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    run_op(1'b1, 3'd7, 64'hFFF9, 64'h0005, 5'd4, 0, "after_rst16");

    repeat (3) @(posedge clk);
    check("q32_drained", 64'(exp32_q.size()), 64'd0);
    check("q16_drained", 64'(exp16_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Multi-cycle RV32M execute unit. It performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on operands already read from the register file. It sits beside the combinational integer execute stage: the decoder routes opcode 0110011 with func7=0000001 here, and the unit stalls the front end through hold_flag_o until the result is written back. Operand width is parametrised, and the algorithm is iterative at one bit per cycle.

Parameters:
XLEN, 32, operand/result width (legal values 8..64)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request: operands and func3 valid this cycle
func3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  in  XLEN  rs1 data
op2_i  in  XLEN  rs2 data
rd_addr_i  in  5  destination register
kill_i  in  1  flush from taken jump/branch; aborts any operation
busy_o  out  1  state != IDLE
hold_flag_o  out  1  stall request to pipeline control
rd_addr_o  out  5  destination of result
rd_data_o  out  XLEN  result
rd_wr_en_o  out  1  write-back strobe, one cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0.
- All outputs 0 during reset: busy_o, hold_flag_o, rd_addr_o, rd_data_o, rd_wr_en_o.
- States: IDLE, CALC, DONE.
- IDLE -> CALC: on start_i && !kill_i, normal case.
  - Latch func3, rd_addr, |op1|, |op2|, and the sign flags.
  - |x| is the two's complement magnitude, taken only when the operand is treated as signed: op1 for MUL/MULH/MULHSU/DIV/REM, op2 for MUL/MULH/DIV/REM.
  - Set counter=XLEN.
- IDLE -> DONE directly (special cases, result computed at accept):
  - Divide by zero (op2=0): DIV/DIVU result all-ones; REM/REMU result op1.
  - Signed overflow (op1=MIN_INT, op2=-1): DIV result MIN_INT; REM result 0.
- CALC:
  - Multiply: shift-add into a 2*XLEN accumulator, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle; the remainder register is XLEN+1 bits.
  - Counter decrements each cycle; at counter==1 go to DONE.
  - CALC therefore lasts exactly XLEN cycles.
- Sign fixup is applied on the CALC->DONE edge and registered into rd_data_o.
  - MUL returns the low XLEN bits of the product, negated if the operands' signs differ.
  - MULH returns the high XLEN bits, negated if signs differ (2*XLEN negation).
  - MULHSU returns the high XLEN bits, negated if op1 is negative.
  - MULHU returns the high XLEN bits, never negated.
  - DIV returns the quotient, negated if signs differ.
  - REM returns the remainder, negated if op1 is negative.
- DONE: lasts one cycle, then IDLE.
  - rd_wr_en_o=1 iff rd_addr!=0.
  - rd_addr_o and rd_data_o are valid and held until the next DONE.
- Latency from the start_i accept edge to rd_wr_en_o high:
  - normal case: XLEN+1 cycles;
  - special case: 1 cycle.
- hold_flag_o = (state==IDLE && start_i && !kill_i) || state==CALC.
  - It is combinational, so the instruction is frozen in EX from the request cycle.
  - It is low in DONE so the pipeline advances as the result is written.
- start_i outside IDLE is ignored, with no queueing.
- kill_i in CALC or DONE: the next state is IDLE and rd_wr_en_o stays 0.
  - kill_i has priority over DONE write-back.
- kill_i with start_i in IDLE: the request is not accepted.
- Reset mid-operation: immediate abort and no write.

Test Plan:
1. MUL op1=7, op2=0xFFFFFFFD (XLEN=32) -> rd_data_o=0xFFFFFFEB. rd_wr_en_o must rise exactly 33 cycles after the accept edge, and hold_flag_o must be high for cycles 0..32.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, each with 1-cycle latency. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with 1-cycle latency.
4. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
5. Start MUL, assert kill_i at CALC cycle 10 -> no rd_wr_en_o, busy_o low next cycle, and a new start_i accepted the following cycle. A start_i pulsed mid-CALC does not alter the result. rd_addr_i=0 -> rd_wr_en_o stays 0.
6. XLEN=16 instance: MUL 0x00FF×0x0101 -> 0xFFFF with 17-cycle latency. Drop rst_n mid-CALC -> all outputs 0 immediately.
